// File: rtl/corescore_stream_uart.sv
// AXI-stream to UART transmitter: elastic FIFO, baud divider, 1 or 2 stop
// bits, end-of-message pulse on tlast and a stretched activity LED.
//
// state | meaning
// IDLE  | line high; pops the next FIFO entry when one is waiting
// START | start bit (line low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit(s), line high for STOP_BITS bit times
module corescore_stream_uart #(
  parameter int CLK_FREQ   = 16000000,
  parameter int BAUD       = 57600,
  parameter int DEPTH_LOG2 = 4,
  parameter int STOP_BITS  = 1,
  parameter int LED_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_tdata,
  input  logic                  i_tlast,
  input  logic                  i_tvalid,
  output logic                  o_tready,
  output logic                  o_uart_tx,
  output logic                  o_led,
  output logic [DEPTH_LOG2:0]   o_fill,
  output logic                  o_msg_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int DEPTH        = 2 ** DEPTH_LOG2;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  localparam int DIV_W        = (STOP_CLKS < 2) ? 1 : $clog2(STOP_CLKS);
  localparam int LED_W        = (LED_CYCLES < 1) ? 1 : $clog2(LED_CYCLES + 1);

  localparam logic [DIV_W-1:0]      DIV_BIT   = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0]      DIV_STOP  = DIV_W'(STOP_CLKS - 1);
  localparam logic [DEPTH_LOG2:0]   FILL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [LED_W-1:0]      LED_LOAD  = LED_W'(LED_CYCLES);

  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("corescore_stream_uart: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("corescore_stream_uart: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_next;
  logic [8:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]    fill, fill_next;
  logic [8:0]             rd_data;
  logic                   tready_q;
  logic                   push, pop;
  logic [DIV_W-1:0]       div;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   last_q;
  logic                   bit_end;
  logic                   tx_next, done_next;
  logic                   tx_q, done_q;
  logic [LED_W-1:0]       led_cnt;
  logic                   led_q;

  assign push    = i_tvalid & tready_q;
  assign rd_data = mem[rd_ptr];
  assign bit_end = (div == '0);

  // occupancy after this cycle's push/pop; drives the registered ready
  always_comb begin
    fill_next = fill;
    if (push && !pop)      fill_next = fill + 1'b1;
    else if (!push && pop) fill_next = fill - 1'b1;
  end

  // FIFO storage; entries are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_tlast, i_tdata};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fill <= fill_next;
    end
  end

  // transmitter state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // next state, pop request and the line level for the next cycle
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fill != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx_next = shreg[0];
        if (bit_end && bit_cnt == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          done_next  = last_q;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // bit timing and shift register; divider reloads at every bit boundary
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      last_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= rd_data[7:0];
            last_q  <= rd_data[8];
            div     <= DIV_BIT;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (bit_end) div <= DIV_BIT;
          else         div <= div - 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            div     <= (bit_cnt == 3'd7) ? DIV_STOP : DIV_BIT;
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            div <= div - 1'b1;
          end
        end
        STOP: begin
          if (!bit_end) div <= div - 1'b1;
        end
        default: div <= '0;
      endcase
    end
  end

  // registered line, end-of-message pulse and stream ready
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      tx_q     <= tx_next;
      done_q   <= done_next;
      tready_q <= (fill_next != FILL_FULL);
    end
  end

  // activity LED: held while framing, counts down once the FSM is idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      led_cnt <= '0;
      led_q   <= 1'b0;
    end else if (state != IDLE) begin
      led_cnt <= LED_LOAD;
      led_q   <= (LED_LOAD != '0);
    end else if (led_cnt != '0) begin
      led_cnt <= led_cnt - 1'b1;
      led_q   <= (led_cnt != LED_W'(1));
    end else begin
      led_q   <= 1'b0;
    end
  end

  assign o_tready   = tready_q;
  assign o_uart_tx  = tx_q;
  assign o_led      = led_q;
  assign o_fill     = fill;
  assign o_msg_done = done_q;

endmodule

// File: tb/tb_corescore_stream_uart.sv
// Directed bench: one instance with a 4-deep FIFO and one stop bit, one
// instance with two stop bits; both run at 8 clocks per bit.
module tb_corescore_stream_uart;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tdata;
  logic       tlast;
  logic       tvalid_a, tvalid_b;
  logic       tready_a, tx_a, led_a, done_a;
  logic       tready_b, tx_b, led_b, done_b;
  logic [2:0] fill_a;
  logic [4:0] fill_b;

  logic [7:0] vb [8];
  logic       vl [8];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  corescore_stream_uart #(
    .CLK_FREQ(8), .BAUD(1), .DEPTH_LOG2(2), .STOP_BITS(1), .LED_CYCLES(20)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast),
    .i_tvalid(tvalid_a), .o_tready(tready_a), .o_uart_tx(tx_a),
    .o_led(led_a), .o_fill(fill_a), .o_msg_done(done_a)
  );

  corescore_stream_uart #(
    .CLK_FREQ(8), .BAUD(1), .DEPTH_LOG2(4), .STOP_BITS(2), .LED_CYCLES(20)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast),
    .i_tvalid(tvalid_b), .o_tready(tready_b), .o_uart_tx(tx_b),
    .o_led(led_b), .o_fill(fill_b), .o_msg_done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected line level after edge e when bytes vb[0..n-1] are accepted from
  // edge 0 and sent back to back: 8 start, 64 data, stop_len stop, 1 idle
  function automatic logic exp_tx(input int e, input int n, input int stop_len);
    int per, off, f;
    logic [7:0] b;
    per = 73 + stop_len;
    if (e < 2) return 1'b1;
    f   = (e - 2) / per;
    off = (e - 2) % per;
    if (f >= n) return 1'b1;
    b = vb[f];
    if (off < 8)  return 1'b0;
    if (off < 72) return b[(off - 8) / 8];
    return 1'b1;
  endfunction

  // backpressure: 5 accepts on edges 0-4, then one per freed slot
  function automatic logic exp_accept(input int e);
    if (e <= 4) return 1'b1;
    if (e == 83 || e == 164 || e == 245) return 1'b1;
    return 1'b0;
  endfunction

  // mode 0: line/done only; 1: also LED and fill for a lone byte;
  // 2: also acceptance pattern and fill/ready under backpressure
  task automatic run_stream(input bit use_b, input int n, input int ncyc, input int stop_len,
                            input int done_edge, input int mode, input string tag);
    int idx;
    bit acc, rdy;
    logic obs_tx, obs_done;
    idx = 0;
    for (int e = 0; e < ncyc; e++) begin
      tdata = (idx < n) ? vb[idx] : 8'h00;
      tlast = (idx < n) ? vl[idx] : 1'b0;
      tvalid_a = !use_b && (idx < n);
      tvalid_b =  use_b && (idx < n);
      rdy = use_b ? tready_b : tready_a;
      acc = (idx < n) && rdy;
      tick();
      if (acc) idx++;
      obs_tx   = use_b ? tx_b : tx_a;
      obs_done = use_b ? done_b : done_a;
      chk({tag, "_tx"}, 32'(obs_tx), 32'(exp_tx(e, n, stop_len)));
      chk({tag, "_done"}, 32'(obs_done), 32'(e == done_edge));
      if (mode == 1) begin
        chk({tag, "_led"}, 32'(led_a), 32'(e >= 2 && e <= 100));
        if (e == 0) chk({tag, "_fill0"}, 32'(fill_a), 32'd1);
        if (e == 1) chk({tag, "_fill1"}, 32'(fill_a), 32'd0);
      end
      if (mode == 2) begin
        chk({tag, "_accept"}, 32'(acc), 32'(exp_accept(e)));
        if (e >= 5 && e <= 81) begin
          chk({tag, "_fill_full"}, 32'(fill_a), 32'd4);
          chk({tag, "_ready_low"}, 32'(tready_a), 32'd0);
        end
        if (e == 82) begin
          chk({tag, "_fill_after_pop"}, 32'(fill_a), 32'd3);
          chk({tag, "_ready_back"}, 32'(tready_a), 32'd1);
        end
        if (e == 83) chk({tag, "_refill"}, 32'(fill_a), 32'd4);
      end
    end
    tvalid_a = 1'b0;
    tvalid_b = 1'b0;
    chk({tag, "_count"}, 32'(idx), 32'(n));
  endtask

  initial begin
    rst = 1'b1; tdata = '0; tlast = 1'b0; tvalid_a = 1'b0; tvalid_b = 1'b0;
    tick();
    tick();
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_tready", 32'(tready_a), 32'd0);
    chk("rst_led", 32'(led_a), 32'd0);
    chk("rst_fill", 32'(fill_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    rst = 1'b0;
    tick();
    chk("rel_tready", 32'(tready_a), 32'd1);
    chk("rel_tready_b", 32'(tready_b), 32'd1);

    // single byte 0x41 with LED stretch
    vb[0] = 8'h41; vl[0] = 1'b0;
    run_stream(1'b0, 1, 106, 8, -1, 1, "single");

    // backpressure with eight bytes queued
    for (int i = 0; i < 8; i++) begin
      vb[i] = 8'h10 + 8'(i * 17);
      vl[i] = 1'b0;
    end
    run_stream(1'b0, 8, 660, 8, -1, 2, "bp");

    // end of message on the second byte only
    vb[0] = 8'h48; vl[0] = 1'b0;
    vb[1] = 8'h69; vl[1] = 1'b1;
    run_stream(1'b0, 2, 175, 8, 162, 0, "msg");

    // two stop bits, back to back
    vb[0] = 8'h0F; vl[0] = 1'b0;
    vb[1] = 8'hF0; vl[1] = 1'b0;
    run_stream(1'b1, 2, 190, 16, -1, 0, "stop2");

    // reset during data bit 3 with three more bytes queued
    vb[0] = 8'hA5; vl[0] = 1'b1;
    vb[1] = 8'h11; vl[1] = 1'b1;
    vb[2] = 8'h22; vl[2] = 1'b0;
    vb[3] = 8'h33; vl[3] = 1'b1;
    for (int e = 0; e < 36; e++) begin
      tvalid_a = (e < 4);
      tdata    = (e < 4) ? vb[e] : 8'h00;
      tlast    = (e < 4) ? vl[e] : 1'b0;
      if (e == 35) rst = 1'b1;
      tick();
      if (e < 35) begin
        chk("abort_tx", 32'(tx_a), 32'(exp_tx(e, 1, 8)));
        if (e == 3) chk("abort_fill_pre", 32'(fill_a), 32'd3);
      end
    end
    tvalid_a = 1'b0;
    chk("abort_line_high", 32'(tx_a), 32'd1);
    chk("abort_fill_zero", 32'(fill_a), 32'd0);
    chk("abort_no_done", 32'(done_a), 32'd0);
    chk("abort_ready_low", 32'(tready_a), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_ready_back", 32'(tready_a), 32'd1);
    for (int e = 0; e < 20; e++) begin
      tick();
      chk("abort_idle_tx", 32'(tx_a), 32'd1);
      chk("abort_idle_done", 32'(done_a), 32'd0);
      chk("abort_idle_fill", 32'(fill_a), 32'd0);
    end
    vb[0] = 8'h55; vl[0] = 1'b0;
    run_stream(1'b0, 1, 90, 8, -1, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/corescore_stream_uart.md
Name: corescore_stream_uart

Overview:
- Parametrised AXI-stream-to-UART transmitter. Sits between corescorecore's byte stream and the board UART pin.
- Extends the current emitter path with:
  - a configurable-depth elastic FIFO;
  - a generic baud divider;
  - selectable stop-bit count;
  - an end-of-message pulse driven by tlast;
  - a stretched activity LED, so board tops stop mirroring raw TX onto an LED.

Parameters:
CLK_FREQ, 16000000, input clock frequency in Hz
BAUD, 57600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2)
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries of {tlast, tdata}
STOP_BITS, 1, number of stop bits, 1 or 2 (other values are an elaboration error)
LED_CYCLES, 1000000, cycles o_led stays high after the transmitter goes idle

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_tdata  in  8  stream byte
i_tlast  in  1  byte ends a message
i_tvalid  in  1  stream valid
o_tready  out  1  stream ready
o_uart_tx  out  1  serial line, idle high
o_led  out  1  stretched TX activity
o_fill  out  DEPTH_LOG2+1  FIFO occupancy; the byte in the shifter is not counted
o_msg_done  out  1  one-cycle pulse when a tlast byte finishes its final stop bit

Behaviour:
Reset:
- Values on the cycle after the reset edge: o_uart_tx=1, o_tready=0, o_led=0, o_fill=0, o_msg_done=0.
- o_tready goes to 1 on the first cycle after i_rst deasserts.
- Reset mid-frame aborts the frame. The line is high on the next cycle, the FIFO is emptied, and no o_msg_done pulse is produced.

FIFO:
- Write occurs when i_tvalid & o_tready.
- o_tready = !full and is registered.
- Pop occurs only when the FSM is in IDLE and the FIFO is non-empty.
- Simultaneous push and pop leaves o_fill unchanged.
- Pointer wrap-around is modulo 2**DEPTH_LOG2.
- A push when full is impossible, because tready is low.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: o_uart_tx=1. If the FIFO is non-empty, pop into a shift register and latch last; next state is START.
- START: line 0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit counter wraps 7->0 on the exit to STOP.
- STOP: line 1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
  - If latched last=1, o_msg_done=1 on the final STOP cycle only.
- Timing:
  - A byte accepted in cycle N into an empty, idle block is popped at N+1; the start bit appears on o_uart_tx at N+2.
  - Back-to-back bytes spend exactly one IDLE cycle between frames.
- The divider counter is reloaded at every bit boundary; there is no cumulative drift.

LED:
- The counter is held at LED_CYCLES while the FSM is not in IDLE, and decrements to 0 in IDLE.
- o_led = (counter != 0), registered.

Test Plan:
- Single byte (CLK_FREQ=8, BAUD=1, CLKS_PER_BIT=8): 0x41, tlast=0, accepted at cycle 0.
  - Line low for cycles 2-9.
  - Data bits 1,0,0,0,0,0,1,0 for 8 cycles each, over cycles 10-73.
  - High stop for cycles 74-81; no o_msg_done.
- Backpressure (DEPTH_LOG2=2): i_tvalid held high with 8 bytes queued.
  - Exactly 5 bytes are accepted on cycles 0-4; o_fill=4 and o_tready=0 from cycle 5.
  - o_tready returns to 1 the cycle after the first frame's IDLE pop.
  - All bytes appear in order.
- Message end: bytes 0x48, 0x69(tlast=1).
  - o_msg_done pulses exactly once, on the last stop cycle of 0x69, never for 0x48.
- STOP_BITS=2, two back-to-back bytes: stop held 16 cycles, then one IDLE cycle, then the next start bit; no glitch low inside the stop.
- Reset mid-DATA, asserted on bit 3 with 3 bytes queued.
  - Line high and o_fill=0 on the next cycle; no o_msg_done.
  - After release, a new byte 0x55 transmits a clean, correctly timed frame.
- LED (LED_CYCLES=20): o_led rises one cycle after START entry and stays high through the frame. It falls exactly 20 cycles after the FSM enters IDLE with the FIFO empty.
